// File: rtl/systolic_array_sequencer.sv
// Job sequencer for systolic_array: streams k_len operand rows from the buffers,
// waits for compute_done and presents a result handshake with cycle count.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; k_len range check
// S_FEED   | one buffer read per cycle, rows 0..k_len-1
// S_DRAIN  | waiting for array_done (timeout down-counter running)
// S_RESULT | res_valid held with res_err/job_cycles until res_ready
module systolic_array_sequencer #(
   parameter int ROWS     = 64,
   parameter int COLS     = 64,
   parameter int IP_WIDTH = 8,
   parameter int K_MAX    = 128,
   parameter int TIMEOUT  = 1024,
   localparam int AW      = $clog2(K_MAX),
   localparam int KW      = $clog2(K_MAX + 1),
   localparam int IW      = ROWS * IP_WIDTH,
   localparam int WW      = COLS * IP_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   input  logic          abort,
   output logic          busy,
   output logic          buf_rd_en,
   output logic [AW-1:0] buf_rd_addr,
   input  logic [IW-1:0] buf_in_data,
   input  logic [WW-1:0] buf_wt_data,
   output logic          array_en,
   output logic          array_clr,
   output logic [IW-1:0] array_in,
   output logic [WW-1:0] array_wt,
   input  logic          array_done,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          res_err,
   output logic [31:0]   job_cycles
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_RESULT} state_t;

   state_t        state;
   logic [AW-1:0] k_last;
   logic [TW-1:0] tmr;
   logic          abort_hit;
   logic          k_bad;

   assign abort_hit = abort && (state != S_IDLE);
   assign k_bad     = (k_len == '0) || (k_len > KW'(K_MAX));
   assign busy      = (state != S_IDLE);

   // Buffer data lines up with the registered array_en beat; gate it so the array sees 0 otherwise.
   assign array_in  = array_en ? buf_in_data : '0;
   assign array_wt  = array_en ? buf_wt_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         k_last      <= '0;
         tmr         <= '0;
         buf_rd_en   <= 1'b0;
         buf_rd_addr <= '0;
         array_en    <= 1'b0;
         array_clr   <= 1'b0;
         res_valid   <= 1'b0;
         res_err     <= 1'b0;
         job_cycles  <= '0;
      end else begin
         array_en  <= buf_rd_en && !abort_hit;
         array_clr <= buf_rd_en && (buf_rd_addr == '0) && !abort_hit;
         if ((state == S_FEED || state == S_DRAIN) && job_cycles != '1)
            job_cycles <= job_cycles + 32'd1;

         if (abort_hit) begin
            state     <= S_IDLE;
            buf_rd_en <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     job_cycles <= '0;
                     if (k_bad) begin
                        state     <= S_RESULT;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                     end else begin
                        state       <= S_FEED;
                        k_last      <= AW'(k_len - KW'(1));
                        buf_rd_en   <= 1'b1;
                        buf_rd_addr <= '0;
                     end
                  end
               end
               S_FEED: begin
                  if (buf_rd_addr == k_last) begin
                     buf_rd_en <= 1'b0;
                     tmr       <= TW'(TIMEOUT - 1);
                     state     <= S_DRAIN;
                  end else begin
                     buf_rd_addr <= buf_rd_addr + AW'(1);
                  end
               end
               S_DRAIN: begin
                  // The final beat is still in flight while array_en is high; a done then is stale.
                  if (array_done && !array_en) begin
                     state     <= S_RESULT;
                     res_valid <= 1'b1;
                     res_err   <= 1'b0;
                  end else if (tmr == '0) begin
                     state     <= S_RESULT;
                     res_valid <= 1'b1;
                     res_err   <= 1'b1;
                  end else begin
                     tmr <= tmr - TW'(1);
                  end
               end
               S_RESULT: begin
                  if (res_ready) begin
                     state     <= S_IDLE;
                     res_valid <= 1'b0;
                     res_err   <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Scoreboard bench for systolic_array_sequencer: the driver queues expected reads,
// array beats and results; a negedge monitor pops and compares them.
module tb_systolic_array_sequencer;
   localparam int ROWS = 4, COLS = 4, IP_WIDTH = 8, K_MAX = 128, TIMEOUT = 16;
   localparam int AW = $clog2(K_MAX), KW = $clog2(K_MAX + 1);
   localparam int IW = ROWS * IP_WIDTH, WW = COLS * IP_WIDTH;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic          array_done = 1'b0, res_ready = 1'b0;
   logic [KW-1:0] k_len = '0;
   logic          busy, buf_rd_en, array_en, array_clr, res_valid, res_err;
   logic [AW-1:0] buf_rd_addr;
   logic [IW-1:0] buf_in_data = '0, array_in;
   logic [WW-1:0] buf_wt_data = '0, array_wt;
   logic [31:0]   job_cycles;

   logic [IW-1:0] mem_in [K_MAX];
   logic [WW-1:0] mem_wt [K_MAX];

   typedef struct {logic [IW-1:0] i; logic [WW-1:0] w; logic clr;} beat_t;
   typedef struct {logic err; logic [31:0] cyc;} res_t;
   int    exp_rd[$];
   beat_t exp_beat[$];
   res_t  exp_res[$];

   int checks = 0, errors = 0;
   logic rv_q = 1'b0;

   systolic_array_sequencer #(.ROWS(ROWS), .COLS(COLS), .IP_WIDTH(IP_WIDTH),
                              .K_MAX(K_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort), .busy(busy),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_in_data(buf_in_data),
      .buf_wt_data(buf_wt_data), .array_en(array_en), .array_clr(array_clr),
      .array_in(array_in), .array_wt(array_wt), .array_done(array_done),
      .res_valid(res_valid), .res_ready(res_ready), .res_err(res_err),
      .job_cycles(job_cycles));

   always #5 clk = ~clk;

   // Operand SRAM model: one-cycle read latency.
   always @(posedge clk) begin
      if (buf_rd_en) begin
         buf_in_data <= mem_in[buf_rd_addr];
         buf_wt_data <= mem_wt[buf_rd_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=unexpected expected=none t=%0t", name, $time);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         rv_q = 1'b0;
      end else begin
         if (buf_rd_en) begin
            if (exp_rd.size() == 0) fail("unexpected_read");
            else chk("rd_addr", 64'(buf_rd_addr), 64'(exp_rd.pop_front()));
         end
         if (array_en) begin
            if (exp_beat.size() == 0) fail("unexpected_beat");
            else begin
               beat_t b;
               b = exp_beat.pop_front();
               chk("array_in", 64'(array_in), 64'(b.i));
               chk("array_wt", 64'(array_wt), 64'(b.w));
               chk("array_clr", 64'(array_clr), 64'(b.clr));
            end
         end else begin
            chk("idle_clr", 64'(array_clr), 64'd0);
            chk("idle_in", 64'(array_in), 64'd0);
         end
         if (res_valid && !rv_q) begin
            if (exp_res.size() == 0) fail("unexpected_result");
            else begin
               res_t r;
               r = exp_res.pop_front();
               chk("res_err", 64'(res_err), 64'(r.err));
               chk("job_cycles", 64'(job_cycles), 64'(r.cyc));
            end
         end
         rv_q = res_valid;
      end
   end

   task automatic issue_start(input int k);
      @(negedge clk);
      start = 1'b1;
      k_len = KW'(k);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic push_job(input int nrd, input int nbeat);
      for (int a = 0; a < nrd; a++) exp_rd.push_back(a);
      for (int a = 0; a < nbeat; a++) exp_beat.push_back('{mem_in[a], mem_wt[a], a == 0});
   endtask

   task automatic wait_res(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("res_valid_timeout");
   endtask

   // Hold res_ready low for hold cycles, then release (optionally with a start that must be ignored).
   task automatic finish_res(input int hold, input logic e, input logic [31:0] c, input bit sr);
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 64'(res_valid), 64'd1);
         chk("hold_err", 64'(res_err), 64'(e));
         chk("hold_cycles", 64'(job_cycles), 64'(c));
         @(negedge clk);
      end
      res_ready = 1'b1;
      if (sr) begin
         start = 1'b1;
         k_len = KW'(3);
      end
      @(posedge clk);
      #1 res_ready = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("post_busy", 64'(busy), 64'd0);
      chk("post_valid", 64'(res_valid), 64'd0);
      if (sr) begin
         @(negedge clk);
         chk("ignored_start_busy", 64'(busy), 64'd0);
      end
   endtask

   // d>0: array_done d cycles after the last beat; d==0: never (timeout).
   task automatic run_job(input int k, input int d, input int hold, input bit sr);
      bit ok;
      logic e;
      logic [31:0] c;
      if (k < 1 || k > K_MAX) begin
         e = 1'b1;
         c = 32'd0;
         exp_res.push_back('{e, c});
         issue_start(k);
         chk("illegal_busy", 64'(busy), 64'd1);
         wait_res(2, ok);
      end else begin
         e = (d == 0);
         c = (d == 0) ? 32'(k + TIMEOUT) : 32'(k + 1 + d);
         push_job(k, k);
         exp_res.push_back('{e, c});
         issue_start(k);
         if (d > 0) begin
            repeat (k + d) @(posedge clk);
            #1 array_done = 1'b1;
            @(posedge clk);
            #1 array_done = 1'b0;
         end
         wait_res(k + TIMEOUT + 10, ok);
      end
      if (ok) finish_res(hold, e, c, sr);
      chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
      chk("beat_queue_empty", 64'(exp_beat.size()), 64'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      for (int a = 0; a < K_MAX; a++) begin
         mem_in[a] = IW'($urandom);
         mem_wt[a] = WW'($urandom);
      end
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd_en", 64'(buf_rd_en), 64'd0);
      chk("rst_array_en", 64'(array_en), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_job_cycles", 64'(job_cycles), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_job(4, 3, 0, 1'b0);
      run_job(4, 3, 5, 1'b1);
      run_job(0, 0, 1, 1'b0);
      run_job(K_MAX + 1, 0, 0, 1'b0);
      run_job(5, 0, 2, 1'b0);
      for (int i = 0; i < 6; i++)
         run_job($urandom_range(1, 20), $urandom_range(1, 6), $urandom_range(0, 4), 1'b0);

      // Abort at beat 50 of a K_MAX job.
      push_job(52, 51);
      issue_start(K_MAX);
      repeat (51) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_array_en", 64'(array_en), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rd_en", 64'(buf_rd_en), 64'd0);
      repeat (TIMEOUT + 10) @(negedge clk);
      chk("abort_rd_queue", 64'(exp_rd.size()), 64'd0);
      chk("abort_beat_queue", 64'(exp_beat.size()), 64'd0);
      run_job(2, 2, 1, 1'b0);

      // Asynchronous reset mid-FEED.
      push_job(10, 10);
      issue_start(10);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_rd_en", 64'(buf_rd_en), 64'd0);
      chk("arst_array_en", 64'(array_en), 64'd0);
      chk("arst_array_clr", 64'(array_clr), 64'd0);
      chk("arst_array_in", 64'(array_in), 64'd0);
      chk("arst_res_valid", 64'(res_valid), 64'd0);
      exp_rd.delete();
      exp_beat.delete();
      exp_res.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_job(1, $urandom_range(1, 4), 0, 1'b0);
      run_job(K_MAX, $urandom_range(1, 4), 0, 1'b0);
      chk("res_queue_empty", 64'(exp_res.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
